// File: rtl/alu_operand_loader.sv
// Operand front-end for the ALU: synchronizes and debounces the A/B/F buttons,
// then loads the switch bank into the operand and opcode registers on each accepted press.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw,
    input  logic        key_A,
    input  logic        key_B,
    input  logic        key_F,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  upd,
    output logic        calc_valid
);

    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] D_CNT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [2:0] keys;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] accept;
    logic [2:0] accept_q;
    logic [2:0] seen;

    assign keys = {key_F, key_B, key_A};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            accept_q <= '0;
        end else begin
            sync1    <= keys;
            sync2    <= sync1;
            accept_q <= accept;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        db_state_t        state;
        db_state_t        state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] cnt_inc;
        logic             acc;

        assign cnt_inc   = cnt + ONE_CNT;
        assign accept[i] = acc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= REL;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            acc       = 1'b0;
            unique case (state)
                REL: begin
                    if (sync2[i]) begin
                        cnt_nxt = ONE_CNT;
                        if (D_CNT == ONE_CNT) begin
                            state_nxt = PRESSED;
                            acc       = 1'b1;
                        end else begin
                            state_nxt = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        cnt_nxt   = '0;
                        state_nxt = REL;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == D_CNT) begin
                            state_nxt = PRESSED;
                            acc       = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!sync2[i]) begin
                        cnt_nxt   = ONE_CNT;
                        state_nxt = (D_CNT == ONE_CNT) ? REL : REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (sync2[i]) begin
                        cnt_nxt   = '0;
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == D_CNT) begin
                            state_nxt = REL;
                        end
                    end
                end
                default: begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Loads happen one edge after the accept, so upd lines up with the new register value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            upd        <= '0;
            seen       <= '0;
            calc_valid <= 1'b0;
        end else begin
            if (accept_q[0]) alu_a  <= sw;
            if (accept_q[1]) alu_b  <= sw;
            if (accept_q[2]) alu_op <= sw[31:28];
            upd        <= accept_q;
            seen       <= seen | accept_q;
            calc_valid <= calc_valid | (&(seen | accept_q));
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader (D=4): scoreboard of expected loads popped
// whenever a strobe appears, plus per-scenario latency and value checks.
module tb_alu_operand_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic        key_A;
    logic        key_B;
    logic        key_F;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [2:0]  upd;
    logic        calc_valid;

    typedef struct packed {
        logic [2:0]  upd;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .key_A      (key_A),
        .key_B      (key_B),
        .key_F      (key_F),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .upd        (upd),
        .calc_valid (calc_valid)
    );

    always #5 clk = ~clk;

    // Every strobe must match the oldest outstanding expected load.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && upd !== 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe upd=%b a=%h b=%h op=%h (no load pending)",
                         upd, alu_a, alu_b, alu_op);
            end else begin
                e = sb.pop_front();
                if ({upd, alu_a, alu_b, alu_op} !== e) begin
                    failures++;
                    $display("FAIL load_contents got upd=%b a=%h b=%h op=%h want upd=%b a=%h b=%h op=%h",
                             upd, alu_a, alu_b, alu_op, e.upd, e.a, e.b, e.op);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [2:0] which);
        if (which[0]) m_a  = sw;
        if (which[1]) m_b  = sw;
        if (which[2]) m_op = sw[31:28];
        sb.push_back({which, m_a, m_b, m_op});
    endtask

    // Counts edges from the first edge sampling the key until upd[bit_i] is seen.
    task automatic measure(input int bit_i, output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd[bit_i] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 32'hDEAD_BEEF; key_A = 0; key_B = 0; key_F = 0;
        m_a = '0; m_b = '0; m_op = '0;
        repeat (3) tick();
        checks++;
        if ({alu_a, alu_b, alu_op, upd, calc_valid} !== '0) begin
            failures++;
            $display("FAIL reset_state a=%h b=%h op=%h upd=%b cv=%b required all 0",
                     alu_a, alu_b, alu_op, upd, calc_valid);
        end
        rst_n = 1'b1;
        repeat (100) tick();
        checks++;
        if ({alu_a, alu_b, alu_op, upd, calc_valid} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset a=%h b=%h op=%h upd=%b cv=%b required all 0",
                     alu_a, alu_b, alu_op, upd, calc_valid);
        end
    endtask

    task automatic test_basic_load();
        int n;
        sw = 32'h0000_000A;
        push_load(3'b001);
        key_A = 1'b1;
        measure(0, n);
        checks++;
        if (n != D + 3) begin
            failures++;
            $display("FAIL press_latency got=%0d required=%0d", n, D + 3);
        end
        @(negedge clk);
        checks++;
        if (upd !== 3'b000) begin
            failures++;
            $display("FAIL strobe_width upd=%b required=000", upd);
        end
        key_A = 1'b0;
        checks++;
        if (alu_a !== 32'h0000_000A) begin
            failures++;
            $display("FAIL load_a got=%h required=0000000a", alu_a);
        end
        repeat (10) tick();
        checks++;
        if (calc_valid !== 1'b0) begin
            failures++;
            $display("FAIL calc_valid_early got=%b required=0", calc_valid);
        end
        sw = 32'h0000_0014;
        push_load(3'b010);
        key_B = 1'b1; repeat (10) tick(); key_B = 1'b0; repeat (10) tick();
        checks++;
        if (alu_b !== 32'h0000_0014) begin
            failures++;
            $display("FAIL load_b got=%h required=00000014", alu_b);
        end
        sw = 32'h8000_0000;
        push_load(3'b100);
        key_F = 1'b1; repeat (10) tick(); key_F = 1'b0; repeat (10) tick();
        checks++;
        if (alu_op !== 4'b1000 || calc_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_f op=%b cv=%b required op=1000 cv=1", alu_op, calc_valid);
        end
        wait_drain("basic");
    endtask

    task automatic test_bounce();
        sw = 32'h0000_5555;
        key_A = 1'b1; repeat (2) tick();
        key_A = 1'b0; repeat (1) tick();
        key_A = 1'b1; repeat (3) tick();
        key_A = 1'b0; repeat (12) tick();
        checks++;
        if (alu_a !== m_a) begin
            failures++;
            $display("FAIL bounce_reject a=%h required=%h", alu_a, m_a);
        end
        push_load(3'b001);
        key_A = 1'b1; repeat (10) tick(); key_A = 1'b0; repeat (10) tick();
        checks++;
        if (alu_a !== 32'h0000_5555) begin
            failures++;
            $display("FAIL bounce_then_hold a=%h required=00005555", alu_a);
        end
        wait_drain("bounce");
    endtask

    task automatic test_hold_change_sw();
        sw = 32'h0000_0019;
        push_load(3'b010);
        key_B = 1'b1;
        repeat (20) tick();
        sw = 32'hFFFF_FFF6;
        repeat (30) tick();
        checks++;
        if (alu_b !== 32'h0000_0019) begin
            failures++;
            $display("FAIL hold_keeps_b b=%h required=00000019", alu_b);
        end
        key_B = 1'b0;
        repeat (10) tick();
        push_load(3'b010);
        key_B = 1'b1; repeat (10) tick(); key_B = 1'b0; repeat (10) tick();
        checks++;
        if (alu_b !== 32'hFFFF_FFF6) begin
            failures++;
            $display("FAIL repress_b b=%h required=fffffff6", alu_b);
        end
        wait_drain("hold");
    endtask

    task automatic test_simultaneous();
        sw = 32'h7000_0F0F;
        push_load(3'b101);
        key_A = 1'b1; key_F = 1'b1;
        repeat (10) tick();
        key_A = 1'b0; key_F = 1'b0;
        repeat (10) tick();
        checks++;
        if (alu_a !== 32'h7000_0F0F || alu_op !== 4'b0111) begin
            failures++;
            $display("FAIL simultaneous a=%h op=%b required a=70000f0f op=0111", alu_a, alu_op);
        end
        wait_drain("simul");
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        sw = 32'h1234_5678;
        key_A = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, upd, calc_valid} !== '0) begin
            failures++;
            $display("FAIL async_reset a=%h b=%h op=%h upd=%b cv=%b required all 0",
                     alu_a, alu_b, alu_op, upd, calc_valid);
        end
        sb.delete();
        m_a = '0; m_b = '0; m_op = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        push_load(3'b001);
        measure(0, n);
        checks++;
        if (n != D + 3) begin
            failures++;
            $display("FAIL post_reset_latency got=%0d required=%0d", n, D + 3);
        end
        checks++;
        if (alu_a !== 32'h1234_5678 || calc_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_load a=%h cv=%b required a=12345678 cv=0", alu_a, calc_valid);
        end
        key_A = 1'b0;
        repeat (10) tick();
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bounce();
        test_hold_change_sw();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end stage directly upstream of the multi-function ALU. Takes the 32 board switches and three raw push-buttons (A, B, F) and debounces each button. On each debounced press it captures the switches into the operand A register, the operand B register, or the 4-bit opcode register. It presents clean, stable `alu_a`, `alu_b` and `alu_op` values plus a one-cycle update strobe for the ALU and its flag register.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20, is the number of consecutive stable synchronized samples required to accept a press or a release. Range 1..2^20-1. Set to 1_000_000 for the board build.
- `CNT_W`, default 20, is the debounce counter width.

Ports:
- `clk`, input, 1 bit: system clock. All state is on its rising edge.
- `rst_n`, input, 1 bit: reset. Asynchronous assert, active-low.
- `sw`, input, 32 bits: switch bank. Asynchronous to `clk`. Sampled only at load edges.
- `key_A`, input, 1 bit: raw button, active-high, bouncy. Loads `alu_a`.
- `key_B`, input, 1 bit: raw button, active-high, bouncy. Loads `alu_b`.
- `key_F`, input, 1 bit: raw button, active-high, bouncy. Loads `alu_op`.
- `alu_a`, output, 32 bits: operand A register.
- `alu_b`, output, 32 bits: operand B register.
- `alu_op`, output, 4 bits: opcode register, taken from `sw[31:28]`.
- `upd`, output, 3 bits: one-cycle strobes {F,B,A}. A bit is high in the first cycle its register shows a new value.
- `calc_valid`, output, 1 bit: high once A, B and F have each been loaded at least once since reset. Sticky.

## Operation

- Reset (async, `rst_n`=0): `alu_a`=0, `alu_b`=0, `alu_op`=4'b0000, `upd`=3'b000, `calc_valid`=0. All synchronizers are 0, all debouncers are in REL, and all counters are 0.
- Each key passes through a 2-flop synchronizer, then its own debounce FSM. The three channels are identical and independent.
- Debounce FSM states and transitions (sync input s, counter cnt):
  - REL: released. On s=1, cnt<=1 and go to PRESS_WAIT. When D=1, go directly to PRESSED and fire the accept.
  - PRESS_WAIT: on s=0, cnt<=0 and return to REL (glitch rejected). On s=1, cnt<=cnt+1. When cnt+1 reaches D, go to PRESSED and fire the accept.
  - PRESSED: held. On s=0, cnt<=1 and go to REL_WAIT.
  - REL_WAIT: on s=1, cnt<=0 and return to PRESSED. On s=0, count up. Reaching D goes to REL.
- Accept fires exactly once per press. Holding the key never re-fires. A re-press is possible only after a debounced release.
- On the edge that registers the accept:
  - A: `alu_a`<=`sw`.
  - B: `alu_b`<=`sw`.
  - F: `alu_op`<=`sw[31:28]`. `sw[27:0]` is ignored for F.
  - The matching `upd` bit is high for exactly that following cycle.
- Simultaneous accepts on several channels in the same cycle: all loads occur from the same `sw` sample, and several `upd` bits are high together.
- `calc_valid` is set on the edge where the last of the three has been loaded. It stays high until reset.
- The opcode is stored unchecked; decoding illegal codes is the ALU's responsibility.
- Reset asserted mid-debounce or mid-strobe aborts immediately to reset values. There is no pending load after reset release, even if a key is still held. A key held through reset release counts as a new press: REL sees s=1 two edges after release.

## Timing

- Number edges so that edge 1 is the first edge sampling `key_X`=1, and the key is held stable.
  - Sync stage 2 shows 1 after edge 2.
  - The FSM reaches PRESSED at edge 2+D.
  - The register holds the new value and `upd` bit X=1 after edge D+3.
  - `upd` returns to 0 after edge D+4.
- Press latency: D+3 cycles.
- Release acceptance: D+2 cycles after the key drops.
- A bounce shorter than D synchronized cycles produces no load.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- `sw` is sampled only at the load edge. Changes to `sw` at any other time have no effect.

## Test plan (D=4)

- **Reset state.** Assert `rst_n`=0 with keys idle → `alu_a`=0, `alu_b`=0, `alu_op`=0, `upd`=0, `calc_valid`=0. Release reset with no key presses → nothing changes for 100 cycles.
- **Basic load.**
  - `sw`=32'h0000000A, press A → `alu_a`=0000000A after 7 edges, `upd`=001 for exactly 1 cycle.
  - `sw`=32'h00000014, press B → `alu_b`=00000014.
  - `sw`=32'h80000000, press F → `alu_op`=4'b1000, `calc_valid`=1.
- **Bounce rejection.** Pulse `key_A` high for 2 cycles, low 1, high 3, low → no load, `upd`=0. Then hold for 10 cycles → exactly one load and one strobe.
- **Hold and change switches.** Hold `key_B` for 50 cycles while `sw` changes from 00000019 to FFFFFFF6 after the load → `alu_b` stays 00000019 and there is no second strobe. Release, then re-press → `alu_b`=FFFFFFF6.
- **Simultaneous press.** `sw`=32'h70000F0F, press A and F in the same cycle → `alu_a`=70000F0F, `alu_op`=4'b0111, `upd`=101 for one cycle.
- **Reset mid-debounce.**
  - Press A, then assert `rst_n`=0 at edge 3, then release reset with the key still held → `alu_a` stays 0 until the new debounce completes. The load then happens D+3 edges after the first post-reset sample.
  - `calc_valid` is 0 after this reset.
